// File: rtl/ysyx_25040111_axi_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU to io_master AXI arbiter.
package ysyx_25040111_axi_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_IFU = 2'd1,
        ST_RD_LSU = 2'd2,
        ST_WR_LSU = 2'd3
    } arb_state_e;

    localparam logic [3:0] ID_IFU = 4'd0;
    localparam logic [3:0] ID_LSU = 4'd1;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // One-hot channel routing derived from the FSM state
    typedef struct packed {
        logic ifu_rd;
        logic lsu_rd;
        logic lsu_wr;
    } route_t;

endpackage

// File: rtl/ysyx_25040111_axi_arbiter_muxkey.sv
// Key-indexed lookup mux: lut holds NR_KEY {key, data} pairs, lowest pair in the low bits.
module ysyx_25040111_MuxKey #(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    output logic [DATA_LEN-1:0]                  out,
    input  logic [KEY_LEN-1:0]                   key,
    input  logic [DATA_LEN-1:0]                  default_out,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut
);

    localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

    always_comb begin
        out = default_out;
        for (int i = 0; i < NR_KEY; i++) begin
            if (lut[i*PAIR_LEN+DATA_LEN +: KEY_LEN] == key) begin
                out = lut[i*PAIR_LEN +: DATA_LEN];
            end
        end
    end

endmodule

// File: rtl/ysyx_25040111_axi_arbiter.sv
// Two-master (IFU read, LSU read/write) to one-slave AXI4 arbiter; one transaction in flight,
// grant registered in IDLE, channels of the granted master forwarded combinationally.
module ysyx_25040111_axi_arbiter
    import ysyx_25040111_axi_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    // IFU (m0)
    input  logic        m0_arvalid,
    output logic        m0_arready,
    input  logic [31:0] m0_araddr,
    input  logic [7:0]  m0_arlen,
    input  logic [2:0]  m0_arsize,
    input  logic [1:0]  m0_arburst,
    output logic        m0_rvalid,
    input  logic        m0_rready,
    output logic [31:0] m0_rdata,
    output logic [1:0]  m0_rresp,
    output logic        m0_rlast,
    // LSU (m1)
    input  logic        m1_arvalid,
    output logic        m1_arready,
    input  logic [31:0] m1_araddr,
    input  logic [7:0]  m1_arlen,
    input  logic [2:0]  m1_arsize,
    input  logic [1:0]  m1_arburst,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    output logic [31:0] m1_rdata,
    output logic [1:0]  m1_rresp,
    output logic        m1_rlast,
    input  logic        m1_awvalid,
    output logic        m1_awready,
    input  logic [31:0] m1_awaddr,
    input  logic [7:0]  m1_awlen,
    input  logic [2:0]  m1_awsize,
    input  logic [1:0]  m1_awburst,
    input  logic        m1_wvalid,
    output logic        m1_wready,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    input  logic        m1_wlast,
    output logic        m1_bvalid,
    input  logic        m1_bready,
    output logic [1:0]  m1_bresp,
    // slave (io_master)
    output logic        s_arvalid,
    input  logic        s_arready,
    output logic [31:0] s_araddr,
    output logic [3:0]  s_arid,
    output logic [7:0]  s_arlen,
    output logic [2:0]  s_arsize,
    output logic [1:0]  s_arburst,
    input  logic        s_rvalid,
    output logic        s_rready,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rlast,
    input  logic [3:0]  s_rid,
    output logic        s_awvalid,
    input  logic        s_awready,
    output logic [31:0] s_awaddr,
    output logic [3:0]  s_awid,
    output logic [7:0]  s_awlen,
    output logic [2:0]  s_awsize,
    output logic [1:0]  s_awburst,
    output logic        s_wvalid,
    input  logic        s_wready,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        s_wlast,
    input  logic        s_bvalid,
    output logic        s_bready,
    input  logic [1:0]  s_bresp,
    input  logic [3:0]  s_bid
);

    arb_state_e state_q, state_d;
    logic       last_lsu_q, last_lsu_d;
    logic       lsu_req;
    logic       r_done, b_done;
    logic [2:0] route_bits;
    route_t     route;

    assign lsu_req = m1_awvalid | m1_arvalid;
    assign r_done  = s_rvalid & s_rready & s_rlast;
    assign b_done  = s_bvalid & s_bready;

    // IFU wins unless the LSU is also asking and the IFU held the previous grant
    always_comb begin
        state_d    = state_q;
        last_lsu_d = last_lsu_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_arvalid && (!lsu_req || last_lsu_q)) begin
                    state_d    = ST_RD_IFU;
                    last_lsu_d = 1'b0;
                end else if (m1_awvalid) begin
                    state_d    = ST_WR_LSU;
                    last_lsu_d = 1'b1;
                end else if (m1_arvalid) begin
                    state_d    = ST_RD_LSU;
                    last_lsu_d = 1'b1;
                end
            end
            ST_RD_IFU, ST_RD_LSU: if (r_done) state_d = ST_IDLE;
            ST_WR_LSU:            if (b_done) state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_lsu_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_lsu_q <= last_lsu_d;
        end
    end

    ysyx_25040111_MuxKey #(
        .NR_KEY  (3),
        .KEY_LEN (2),
        .DATA_LEN(3)
    ) u_route_mux (
        .out        (route_bits),
        .key        (state_q),
        .default_out(3'b000),
        .lut        ({ST_RD_IFU, 3'b100, ST_RD_LSU, 3'b010, ST_WR_LSU, 3'b001})
    );
    assign route = route_t'(route_bits);

    // AR / R
    assign s_arvalid  = (route.ifu_rd & m0_arvalid) | (route.lsu_rd & m1_arvalid);
    assign s_araddr   = route.lsu_rd ? m1_araddr  : m0_araddr;
    assign s_arlen    = route.lsu_rd ? m1_arlen   : m0_arlen;
    assign s_arsize   = route.lsu_rd ? m1_arsize  : m0_arsize;
    assign s_arburst  = route.lsu_rd ? m1_arburst : m0_arburst;
    assign s_arid     = route.lsu_rd ? ID_LSU     : ID_IFU;
    assign s_rready   = (route.ifu_rd & m0_rready) | (route.lsu_rd & m1_rready);

    assign m0_arready = route.ifu_rd & s_arready;
    assign m0_rvalid  = route.ifu_rd & s_rvalid;
    assign m0_rdata   = s_rdata;
    assign m0_rresp   = s_rresp;
    assign m0_rlast   = s_rlast;

    assign m1_arready = route.lsu_rd & s_arready;
    assign m1_rvalid  = route.lsu_rd & s_rvalid;
    assign m1_rdata   = s_rdata;
    assign m1_rresp   = s_rresp;
    assign m1_rlast   = s_rlast;

    // AW / W / B: only the LSU writes
    assign s_awvalid  = route.lsu_wr & m1_awvalid;
    assign s_awaddr   = m1_awaddr;
    assign s_awlen    = m1_awlen;
    assign s_awsize   = m1_awsize;
    assign s_awburst  = m1_awburst;
    assign s_awid     = ID_LSU;
    assign s_wvalid   = route.lsu_wr & m1_wvalid;
    assign s_wdata    = m1_wdata;
    assign s_wstrb    = m1_wstrb;
    assign s_wlast    = m1_wlast;
    assign s_bready   = route.lsu_wr & m1_bready;

    assign m1_awready = route.lsu_wr & s_awready;
    assign m1_wready  = route.lsu_wr & s_wready;
    assign m1_bvalid  = route.lsu_wr & s_bvalid;
    assign m1_bresp   = s_bresp;

    // Responses are steered by state, so a wrong slave ID is flagged but not acted on
    always_ff @(posedge clk) begin
        if (!rst && route.ifu_rd && s_rvalid) assert (s_rid == ID_IFU);
        if (!rst && route.lsu_rd && s_rvalid) assert (s_rid == ID_LSU);
        if (!rst && route.lsu_wr && s_bvalid) assert (s_bid == ID_LSU);
    end

endmodule

// File: tb/tb_ysyx_25040111_axi_arbiter.sv
// Directed plus randomized bench for the IFU/LSU AXI arbiter with a grant-order reference model.
module tb_ysyx_25040111_axi_arbiter;
    import ysyx_25040111_axi_arbiter_pkg::*;

    localparam int G_NONE = 0;
    localparam int G_IFU  = 1;
    localparam int G_LRD  = 2;
    localparam int G_WR   = 3;

    logic clk = 1'b0;
    logic rst;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
    logic [31:0] m0_araddr, m0_rdata;
    logic [7:0]  m0_arlen;
    logic [2:0]  m0_arsize;
    logic [1:0]  m0_arburst, m0_rresp;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
    logic [31:0] m1_araddr, m1_rdata;
    logic [7:0]  m1_arlen;
    logic [2:0]  m1_arsize;
    logic [1:0]  m1_arburst, m1_rresp;
    logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast, m1_bvalid, m1_bready;
    logic [31:0] m1_awaddr, m1_wdata;
    logic [7:0]  m1_awlen;
    logic [2:0]  m1_awsize;
    logic [1:0]  m1_awburst, m1_bresp;
    logic [3:0]  m1_wstrb;
    logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [31:0] s_araddr, s_rdata;
    logic [3:0]  s_arid, s_rid;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst, s_rresp;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
    logic [31:0] s_awaddr, s_wdata;
    logic [3:0]  s_awid, s_wstrb, s_bid;
    logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst, s_bresp, s_bresp_exp;

    int ncmp = 0;
    int nfail = 0;
    bit model_last_lsu;

    always #5 clk = ~clk;

    ysyx_25040111_axi_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
        .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
        .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
        .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
        .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr),
        .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
        .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rid(s_rid),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a lone requester wins; on an IFU/LSU tie the side that did not hold the
    // previous grant wins; within the LSU a write goes before a read.
    function automatic int model_pick(bit ifu, bit lsu_wr, bit lsu_rd);
        bit lsu;
        bit ifu_turn;
        lsu      = lsu_wr | lsu_rd;
        ifu_turn = ifu && (!lsu || model_last_lsu);
        if (ifu_turn) return G_IFU;
        if (lsu_wr)   return G_WR;
        if (lsu_rd)   return G_LRD;
        return G_NONE;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        {m0_arvalid, m0_rready, m1_arvalid, m1_rready, m1_awvalid, m1_wvalid, m1_bready} = '0;
        {s_arready, s_rvalid, s_rlast, s_awready, s_wready, s_bvalid} = '0;
        m0_araddr = '0; m0_arlen = '0; m0_arsize = 3'd2; m0_arburst = AXI_BURST_INCR;
        m1_araddr = '0; m1_arlen = '0; m1_arsize = 3'd2; m1_arburst = AXI_BURST_INCR;
        m1_awaddr = '0; m1_awlen = '0; m1_awsize = 3'd2; m1_awburst = AXI_BURST_INCR;
        m1_wdata = '0; m1_wstrb = '0; m1_wlast = 1'b1;
        s_rdata = '0; s_rresp = '0; s_rid = '0; s_bresp = '0; s_bid = '0;
        tick();
        tick();
        rst = 1'b0;
        model_last_lsu = 1'b1;
    endtask

    task automatic rd_serve(input int g, input logic [1:0] resp, input logic [31:0] d0,
                            input int inject);
        bit ifu;
        int len;
        logic [31:0] d;
        ifu = (g == G_IFU);
        len = ifu ? int'(m0_arlen) : int'(m1_arlen);
        chk("ar_valid", {31'd0, s_arvalid}, 32'd1);
        chk("ar_id", {28'd0, s_arid}, ifu ? {28'd0, ID_IFU} : {28'd0, ID_LSU});
        chk("ar_addr", s_araddr, ifu ? m0_araddr : m1_araddr);
        chk("ar_len", {24'd0, s_arlen}, ifu ? {24'd0, m0_arlen} : {24'd0, m1_arlen});
        chk("rd_no_write", {30'd0, s_awvalid, s_wvalid}, 32'd0);
        s_arready = 1'b1;
        #1;
        chk("ar_ready_route", {30'd0, m0_arready, m1_arready}, ifu ? 32'd2 : 32'd1);
        tick();
        s_arready = 1'b0;
        if (ifu) m0_arvalid = 1'b0; else m1_arvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            if (ifu && b == inject) begin
                m1_arvalid = 1'b1;
                m1_araddr  = $urandom;
                m1_arlen   = 8'd0;
            end
            d = (b == 0) ? d0 : $urandom;
            s_rvalid = 1'b1; s_rdata = d; s_rresp = resp; s_rlast = (b == len);
            s_rid = ifu ? ID_IFU : ID_LSU;
            m0_rready = 1'b1; m1_rready = 1'b1;
            #1;
            chk("r_valid_route", {30'd0, m0_rvalid, m1_rvalid}, ifu ? 32'd2 : 32'd1);
            chk("r_data", ifu ? m0_rdata : m1_rdata, d);
            chk("r_resp", {30'd0, ifu ? m0_rresp : m1_rresp}, {30'd0, resp});
            chk("r_last", {31'd0, ifu ? m0_rlast : m1_rlast}, (b == len) ? 32'd1 : 32'd0);
            chk("s_rready", {31'd0, s_rready}, 32'd1);
            if (ifu) chk("lsu_ar_stalled", {30'd0, m1_arready, s_arvalid}, 32'd0);
            tick();
        end
        s_rvalid = 1'b0; s_rlast = 1'b0;
    endtask

    // order: 0 = W before AW, 1 = AW before W, 2 = same cycle
    task automatic wr_serve(input int order);
        chk("aw_valid", {31'd0, s_awvalid}, 32'd1);
        chk("aw_id", {28'd0, s_awid}, {28'd0, ID_LSU});
        chk("aw_addr", s_awaddr, m1_awaddr);
        chk("w_valid", {31'd0, s_wvalid}, 32'd1);
        chk("w_data", s_wdata, m1_wdata);
        chk("w_strb", {28'd0, s_wstrb}, {28'd0, m1_wstrb});
        chk("wr_ar_blocked", {29'd0, s_arvalid, m0_arready, m1_arready}, 32'd0);
        s_wready  = (order != 1);
        s_awready = (order != 0);
        #1;
        chk("w_ready", {31'd0, m1_wready}, (order != 1) ? 32'd1 : 32'd0);
        chk("aw_ready", {31'd0, m1_awready}, (order != 0) ? 32'd1 : 32'd0);
        tick();
        if (s_wready) m1_wvalid = 1'b0;
        if (s_awready) m1_awvalid = 1'b0;
        s_wready = 1'b0; s_awready = 1'b0;
        if (order != 2) begin
            s_wready = (order == 1); s_awready = (order == 0);
            #1;
            chk("wr_second_ready", {30'd0, m1_awready, m1_wready}, (order == 0) ? 32'd2 : 32'd1);
            chk("wr_ifu_ready0", {31'd0, m0_arready}, 32'd0);
            tick();
            m1_awvalid = 1'b0; m1_wvalid = 1'b0;
            s_wready = 1'b0; s_awready = 1'b0;
        end
        s_bresp_exp = 2'($urandom_range(0, 3));
        s_bvalid = 1'b1; s_bresp = s_bresp_exp; s_bid = ID_LSU; m1_bready = 1'b1;
        #1;
        chk("b_valid", {31'd0, m1_bvalid}, 32'd1);
        chk("b_resp", {30'd0, m1_bresp}, {30'd0, s_bresp_exp});
        chk("b_ready", {31'd0, s_bready}, 32'd1);
        chk("b_ifu_quiet", {30'd0, m0_rvalid, m0_arready}, 32'd0);
        tick();
        s_bvalid = 1'b0; m1_bready = 1'b0;
    endtask

    // Serve every pending request in the order the reference model predicts
    task automatic drain(input logic [1:0] resp, input int inject, input logic [31:0] d0,
                         input int order);
        int g;
        while (m0_arvalid || m1_awvalid || m1_arvalid) begin
            #1;
            chk("idle_quiet", {27'd0, s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, 32'd0);
            g = model_pick(m0_arvalid, m1_awvalid, m1_arvalid);
            tick();
            model_last_lsu = (g != G_IFU);
            if (g == G_WR) wr_serve((order < 0) ? $urandom_range(0, 2) : order);
            else rd_serve(g, resp, d0, inject);
        end
    endtask

    initial begin
        do_reset();
        #1;
        chk("reset_outs", {22'd0, s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
                           m0_arready, m1_arready, m0_rvalid, m1_rvalid, m1_bvalid}, 32'd0);

        // withdrawn before the grant edge: nothing granted
        m0_arvalid = 1'b1;
        #1;
        m0_arvalid = 1'b0;
        tick();
        #1;
        chk("withdrawn_no_grant", {31'd0, s_arvalid}, 32'd0);

        // IFU single fetch
        m0_arvalid = 1'b1; m0_araddr = 32'h3000_0000; m0_arlen = 8'd0;
        drain(AXI_RESP_OKAY, -1, 32'h0000_0413, -1);
        #1;
        chk("ifu_done_idle", {31'd0, s_arvalid}, 32'd0);

        // LSU write, W before AW, IFU requesting throughout
        m1_awvalid = 1'b1; m1_wvalid = 1'b1; m1_awaddr = 32'h8000_0004;
        m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF;
        m0_arvalid = 1'b1; m0_araddr = 32'h3000_0004; m0_arlen = 8'd0;
        drain(AXI_RESP_OKAY, -1, $urandom, 0);

        // simultaneous IFU/LSU reads after reset, two rounds
        do_reset();
        for (int r = 0; r < 2; r++) begin
            m0_arvalid = 1'b1; m0_araddr = $urandom; m0_arlen = 8'd0;
            m1_arvalid = 1'b1; m1_araddr = $urandom; m1_arlen = 8'd0;
            drain(AXI_RESP_OKAY, -1, $urandom, -1);
        end

        // IFU burst of 4 with an LSU read arriving on beat 2; SLVERR passed through
        m0_arvalid = 1'b1; m0_araddr = 32'h3000_0100; m0_arlen = 8'd3;
        drain(AXI_RESP_SLVERR, 1, $urandom, -1);

        // reset with AW/W done and B outstanding
        m1_awvalid = 1'b1; m1_wvalid = 1'b1; m1_awaddr = $urandom; m1_wdata = $urandom;
        m1_wstrb = 4'h3;
        tick();
        model_last_lsu = 1'b1;
        s_awready = 1'b1; s_wready = 1'b1;
        tick();
        m1_awvalid = 1'b0; m1_wvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
        m1_bready = 1'b1;
        do_reset();
        #1;
        chk("rst_mid_write", {25'd0, s_arvalid, s_awvalid, s_wvalid, s_bready,
                              m1_bvalid, m1_awready, m1_wready}, 32'd0);
        m0_arvalid = 1'b1; m0_araddr = $urandom; m0_arlen = 8'd1;
        drain(AXI_RESP_OKAY, -1, $urandom, -1);

        // randomized request mixes
        for (int it = 0; it < 25; it++) begin
            int sel;
            sel = $urandom_range(1, 7);
            m0_arvalid = sel[0]; m0_araddr = $urandom; m0_arlen = 8'($urandom_range(0, 3));
            m1_awvalid = sel[1]; m1_wvalid = sel[1]; m1_awaddr = $urandom;
            m1_wdata = $urandom; m1_wstrb = 4'($urandom_range(0, 15));
            m1_arvalid = sel[2]; m1_araddr = $urandom; m1_arlen = 8'($urandom_range(0, 3));
            drain(2'($urandom_range(0, 3)), -1, $urandom, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
